call_return_stack: RTL



---
 rtl/mpu_pkg.sv | 20 ++
 rtl/call_return_stack_if.sv | 30 +++
 rtl/call_return_stack_rstack_mem.sv | 50 +++++
 rtl/call_return_stack.sv | 102 ++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared MPU definitions: program-memory address type and return-stack defaults,
// used by program_sequencer and call_return_stack.
package mpu_pkg;

  localparam int PM_ADDR_W = 8;
  localparam logic [PM_ADDR_W-1:0] PM_ADDR_MAX = 8'hFF;
  localparam int RSTACK_DEPTH = 4;
  localparam int RSTACK_PTR_W = 3;

  typedef logic [PM_ADDR_W-1:0] pm_addr_t;

  // Operation the return-stack register file performs on a given clock edge.
  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } rstack_op_e;

endpackage

// File: rtl/call_return_stack_if.sv
// Decoder/sequencer-side bundle of the return stack: CALL/RET strobes, the
// current program address, and the stack's return address and status.
interface call_return_stack_if
  import mpu_pkg::*;
#(
  parameter int ADDR_W = PM_ADDR_W,
  parameter int PTR_W  = RSTACK_PTR_W
) ();

  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] pm_addr;
  logic [ADDR_W-1:0] ret_addr;
  logic [PTR_W-1:0]  depth;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output call, ret, pm_addr,
    input  ret_addr, depth, empty, full, overflow, underflow
  );

  modport slave (
    input  call, ret, pm_addr,
    output ret_addr, depth, empty, full, overflow, underflow
  );

endinterface

// File: rtl/call_return_stack_rstack_mem.sv
// Circular DEPTH x ADDR_W register file for return addresses; owns the write
// pointer and exposes the entry just below the top for pops.
module rstack_mem
  import mpu_pkg::*;
#(
  parameter int ADDR_W = PM_ADDR_W,
  parameter int DEPTH  = RSTACK_DEPTH
) (
  input  logic              clk,
  input  logic              sync_reset,
  input  rstack_op_e        op,
  input  logic [ADDR_W-1:0] wr_data,
  output logic [ADDR_W-1:0] next_top
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  logic [ADDR_W-1:0] entries [DEPTH];
  logic [IDX_W-1:0]  wr_ptr;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] i);
    return (i == '0) ? LAST : i - 1'b1;
  endfunction

  // wr_ptr names the slot above the top; a push into a full buffer lands on the oldest entry.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          entries[wr_ptr] <= wr_data;
          wr_ptr          <= idx_inc(wr_ptr);
        end
        OP_POP:     wr_ptr <= idx_dec(wr_ptr);
        OP_REPLACE: entries[idx_dec(wr_ptr)] <= wr_data;
        default: ;
      endcase
    end
  end

  assign next_top = entries[idx_dec(idx_dec(wr_ptr))];

endmodule

// File: rtl/call_return_stack.sv
// Return-address LIFO feeding program_sequencer. Define RSTACK_WRAP_EN to make a
// push into a full stack overwrite the oldest entry instead of being dropped.
module call_return_stack
  import mpu_pkg::*;
#(
  parameter int ADDR_W = PM_ADDR_W,
  parameter int DEPTH  = RSTACK_DEPTH,
  parameter int PTR_W  = RSTACK_PTR_W
) (
  input logic              clk,
  input logic              sync_reset,
  call_return_stack_if.slave bus
);

  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  logic [PTR_W-1:0]  depth_q, depth_nxt;
  logic [ADDR_W-1:0] ret_q, ret_nxt;
  logic [ADDR_W-1:0] push_val, next_top;
  logic              ovf_q, ovf_nxt, unf_q, unf_nxt;
  logic              is_empty, is_full;
  rstack_op_e        mem_op;

  assign push_val = bus.pm_addr + 1'b1;
  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DEPTH_P);

  rstack_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk       (clk),
    .sync_reset(sync_reset),
    .op        (mem_op),
    .wr_data   (push_val),
    .next_top  (next_top)
  );

  // ret_q always mirrors the top entry so a RET sees its target with no latency.
  always_comb begin
    mem_op    = OP_NONE;
    depth_nxt = depth_q;
    ret_nxt   = ret_q;
    ovf_nxt   = ovf_q;
    unf_nxt   = unf_q;
    case ({bus.call, bus.ret})
      2'b10: begin
        if (!is_full) begin
          mem_op    = OP_PUSH;
          depth_nxt = depth_q + 1'b1;
          ret_nxt   = push_val;
        end else begin
          ovf_nxt = 1'b1;
`ifdef RSTACK_WRAP_EN
          mem_op  = OP_PUSH;
          ret_nxt = push_val;
`endif
        end
      end
      2'b01: begin
        if (!is_empty) begin
          mem_op    = OP_POP;
          depth_nxt = depth_q - 1'b1;
          ret_nxt   = (depth_q == ONE_P) ? '0 : next_top;
        end else begin
          unf_nxt = 1'b1;
        end
      end
      2'b11: begin
        // Tail call: an empty stack simply takes the push.
        if (is_empty) begin
          mem_op    = OP_PUSH;
          depth_nxt = ONE_P;
        end else begin
          mem_op = OP_REPLACE;
        end
        ret_nxt = push_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      depth_q <= '0;
      ret_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_nxt;
      ret_q   <= ret_nxt;
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

  assign bus.ret_addr  = ret_q;
  assign bus.depth     = depth_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule
